// File: rtl/mem_port_rr_arbiter_if.sv
// Bundle of the request/grant handshake between four requesters and the
// arbiter that owns the shared data-memory port mux select.
interface mem_port_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout_err;

  // Requester/resource side: raises requests and completion.
  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  valid,
    input  timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output valid,
    output timeout_err
  );
endinterface

// File: rtl/mem_port_rr_arbiter.sv
// Round-robin arbiter for the shared data-memory port. Holds a grant until
// done, withdrawal or watchdog expiry, and re-arbitrates on the same edge so
// back-to-back grants have no idle bubble.
module mem_port_rr_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input logic                  clk,
  input logic                  rst,
  mem_port_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    gnt_reg, gnt_next;
  logic [1:0]    sel_reg, sel_next;
  logic [1:0]    ptr_reg, ptr_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          terr_reg, terr_next;

  logic [2:0]    idle_pick;
  logic [2:0]    re_pick;
  logic          hit;
  logic          release_now;

  // Returns {found, index} of the first set bit of r searching p, p+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + k[1:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Candidate winners: fresh arbitration from IDLE, and same-edge handover
  // after release with the current owner masked out and the pointer advanced.
  always_comb begin
    idle_pick   = rr_pick(bus.req, ptr_reg);
    re_pick     = rr_pick(bus.req & ~gnt_reg, sel_reg + 2'd1);
    hit         = (timer_reg == TW'(TIMEOUT - 1));
    release_now = bus.done | ~bus.req[sel_reg] | hit;
  end

  // Next-state and next-output logic; registers hold by default.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    timer_next = timer_reg;
    terr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (idle_pick[2]) begin
          gnt_next   = 4'b0001 << idle_pick[1:0];
          sel_next   = idle_pick[1:0];
          timer_next = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next   = sel_reg + 2'd1;
          // Completion on the last allowed cycle is a normal release.
          terr_next  = hit & ~bus.done;
          timer_next = '0;
          if (re_pick[2]) begin
            gnt_next = 4'b0001 << re_pick[1:0];
            sel_next = re_pick[1:0];
          end else begin
            gnt_next   = 4'b0000;
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        gnt_next   = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'd0;
      ptr_reg   <= 2'd0;
      timer_reg <= '0;
      terr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      timer_reg <= timer_next;
      terr_reg  <= terr_next;
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.sel         = sel_reg;
  assign bus.valid       = |gnt_reg;
  assign bus.timeout_err = terr_reg;

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Bench for mem_port_rr_arbiter: directed vector table, watchdog sequences,
// and randomized traffic compared against a behavioural model.
module tb_mem_port_rr_arbiter;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_rr_arbiter_if bus ();

  mem_port_rr_arbiter #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       terr;
  } vec_t;

  vec_t vecs [25];

  // Behavioural model: owner index (-1 idle), cycles held, pointer.
  int   m_owner, m_ptr, m_held, m_sel;
  logic m_terr;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_from(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r_rst, input logic [3:0] r_req, input logic r_done);
    int w;
    bit timed_out;
    if (r_rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_terr = 1'b0;
    end else if (m_owner < 0) begin
      m_terr = 1'b0;
      w = first_from(r_req, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_held = 1;
      end
    end else begin
      timed_out = (m_held == TIMEOUT);
      m_terr = timed_out && !r_done;
      if (r_done || !r_req[m_owner] || timed_out) begin
        m_ptr = (m_owner + 1) % 4;
        w = first_from(r_req, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_held = 1;
        end else begin
          m_owner = -1; m_held = 0;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic run_watchdog(input logic done_on_last);
    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    tick();
    rst = 1'b0; bus.req = 4'b0001;
    tick();
    check("wd_first_gnt", 8'(bus.gnt), 8'h01);
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      check("wd_hold_gnt", 8'(bus.gnt), 8'h01);
      check("wd_hold_terr", 8'(bus.timeout_err), 8'h00);
    end
    bus.done = done_on_last;
    tick();
    $display("wd done_last=%b release: gnt=%b valid=%b terr=%b", done_on_last, bus.gnt, bus.valid, bus.timeout_err);
    check("wd_rel_gnt", 8'(bus.gnt), 8'h00);
    check("wd_rel_valid", 8'(bus.valid), 8'h00);
    check("wd_rel_terr", 8'(bus.timeout_err), done_on_last ? 8'h00 : 8'h01);
    bus.done = 1'b0;
    tick();
    $display("wd done_last=%b regrant: gnt=%b terr=%b", done_on_last, bus.gnt, bus.timeout_err);
    check("wd_regrant_gnt", 8'(bus.gnt), 8'h01);
    check("wd_regrant_terr", 8'(bus.timeout_err), 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [3:0] req_cur;
    logic       d, r;

    //            rst req      done gnt      sel   v  t
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b1011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'b1011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};

    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;

    // Directed vectors: one clock edge per row.
    for (int i = 0; i < 25; i++) begin
      rst = vecs[i].rst; bus.req = vecs[i].req; bus.done = vecs[i].done;
      tick();
      $display("vec %0d rst=%b req=%b done=%b -> gnt=%b sel=%0d valid=%b terr=%b",
               i, rst, bus.req, bus.done, bus.gnt, bus.sel, bus.valid, bus.timeout_err);
      check($sformatf("vec%0d_gnt", i),   8'(bus.gnt),         8'(vecs[i].gnt));
      check($sformatf("vec%0d_sel", i),   8'(bus.sel),         8'(vecs[i].sel));
      check($sformatf("vec%0d_valid", i), 8'(bus.valid),       8'(vecs[i].valid));
      check($sformatf("vec%0d_terr", i),  8'(bus.timeout_err), 8'(vecs[i].terr));
    end

    // Watchdog expiry, then completion on the final allowed cycle.
    run_watchdog(1'b0);
    run_watchdog(1'b1);

    // Randomized traffic against the model.
    rst = 1'b1; bus.req = 4'b0000; bus.done = 1'b0;
    model_edge(1'b1, 4'b0000, 1'b0);
    tick();
    req_cur = 4'b0000;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req_cur = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 199) == 0);
      rst = r; bus.req = req_cur; bus.done = d;
      model_edge(r, req_cur, d);
      tick();
      $display("rnd %0d rst=%b req=%b done=%b -> gnt=%b sel=%0d terr=%b",
               c, r, req_cur, d, bus.gnt, bus.sel, bus.timeout_err);
      check("rnd_gnt",   8'(bus.gnt),   (m_owner < 0) ? 8'h00 : 8'(4'b0001 << m_owner));
      check("rnd_sel",   8'(bus.sel),   8'(m_sel));
      check("rnd_valid", 8'(bus.valid), (m_owner < 0) ? 8'h00 : 8'h01);
      check("rnd_terr",  8'(bus.timeout_err), 8'(m_terr));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_rr_arbiter.md
Name: mem_port_rr_arbiter

Overview:
Round-robin arbiter that shares one datapath resource, the data-memory port, among four requesters. It drives the 2-bit select of the shared 4:1 operand/address mux that sits in front of that resource. It holds a grant until the resource signals completion, the requester withdraws, or a watchdog expires. One instance per shared port, placed next to the 4:1 mux it controls.

Parameters:
TIMEOUT, 16, maximum cycles a grant may be held before forced release; legal range 2..255.
TW, 8, width of the internal hold-timer; must satisfy 2^TW > TIMEOUT.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
req  input  4  request vector; bit i = requester i wants the port.
done  input  1  resource completed the current transaction; sampled only while granted.
gnt  output  4  one-hot grant, registered; all-zero when idle.
sel  output  2  mux select, registered; sel = index of granted requester (0->A_00, 1->B_01, 2->C_10, 3->D_11).
valid  output  1  resource-start qualifier; equals |gnt.
timeout_err  output  1  one-cycle pulse on watchdog-forced release.

Behaviour:
- Reset: the synchronous reset is sampled on the clk rising edge. After the edge:
  - gnt=0000, sel=00, valid=0, timeout_err=0.
  - Priority pointer ptr=0, timer=0, state=IDLE.
  - Reset asserted mid-grant aborts the grant without a timeout_err pulse.
- State IDLE: at each edge, if req!=0, select the winner w. w is the first set bit of req searching ptr, ptr+1, ... modulo 4.
  - gnt<=onehot(w), sel<=w, timer<=0, state<=GRANT.
  - Latency: a req rising before edge k gives gnt/valid high after edge k (1 cycle).
- State GRANT: timer increments by 1 every cycle. The grant is released at an edge when any of these hold:
  - (a) done=1;
  - (b) req[w]=0 (withdrawal, no error);
  - (c) timer==TIMEOUT-1 with done=0. This asserts timeout_err for exactly the next cycle.
- Release priority: if (a) and (c) coincide, done wins and there is no timeout_err. (a) and (b) coinciding is a normal release.
- On release:
  - ptr<=(w+1) mod 4.
  - Re-arbitration happens at the same edge using the new ptr and the current req with bit w masked. If another requester is pending, the grant moves directly to it with no idle bubble: gnt switches one-hot to one-hot, valid stays 1, timer<=0.
  - Otherwise the block goes to IDLE with gnt=0000 and sel holding its last value.
- The released requester is excluded from the same-edge re-arbitration only. It may win again on a later edge if it is the only requester.
- sel changes only when a new grant is issued. gnt is always one-hot or zero, never multi-hot.
- done while IDLE is ignored. req changes on non-granted bits during GRANT have no effect.
- Timer saturates logic: it never wraps, because release occurs at TIMEOUT-1.
- Fairness: with all four requesting continuously and done every cycle, grants rotate 0,1,2,3,0,... with no requester starved beyond 3 grants.

Test Plan:
- Reset then single request: req=0100 at cycle 2 -> gnt=0100, sel=10, valid=1 after the next edge. done pulse -> gnt=0000, valid=0; ptr=3 (check via next contention).
- Full contention: req=1111 held, done=1 every granted cycle -> sel sequence 0,1,2,3,0 on consecutive cycles; valid stays 1 throughout; no bubbles.
- Pointer fairness: after requester 1 is served (ptr=2), req=1011 -> next winner is 3, then 0, then 1.
- Watchdog: TIMEOUT=16, req=0001 held, done never -> release on the 16th granted cycle; timeout_err=1 for exactly one cycle; re-grant to 0 occurs only from IDLE on the following edge. done asserted on that same 16th cycle -> no timeout_err.
- Withdrawal: granted requester 2 drops req while req=1000 is pending -> next cycle gnt=1000, sel=11, no timeout_err.
- Reset mid-grant: rst=1 while gnt=0010, timer=5 -> after the edge, all outputs zero, ptr=0; with req=1111 after release, the first winner is 0.
